power_dom_rsp26: RTL

POWER_DOM_RSP26 -- requirements
Module: power_dom_rsp26

---
 rtl/power_dom_rsp26.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/power_dom_rsp26.sv
// Power-switch sequencer for a switchable domain: weak/strong switch ramps,
// retention save/restore handshake, sticky protocol error flags and power-off counter.
module power_dom_rsp26 #(
    parameter int unsigned RAMP_DN_CYC = 4,
    parameter int unsigned RAMP1_CYC   = 8,
    parameter int unsigned RAMP2_CYC   = 16
) (
    input  logic       pclk26,
    input  logic       nprst26,
    input  logic       pwr1_on26,
    input  logic       pwr2_on26,
    input  logic       isolate_module26,
    input  logic       gate_clk_module26,
    input  logic       save_edge26,
    input  logic       restore_edge26,
    input  logic       clr_err26,
    output logic       pwr1_ack26,
    output logic       pwr_good26,
    output logic       retain_valid26,
    output logic       restore_done26,
    output logic [3:0] err26,
    output logic [7:0] pso_count26
);

    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_DN_RAMP = 3'd1,
        ST_OFF     = 3'd2,
        ST_UP1     = 3'd3,
        ST_UP2     = 3'd4
    } state_t;

    localparam logic [7:0] DN_LOAD  = 8'(RAMP_DN_CYC - 32'd1);
    localparam logic [7:0] UP1_LOAD = 8'(RAMP1_CYC - 32'd1);
    localparam logic [7:0] UP2_LOAD = 8'(RAMP2_CYC - 32'd1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        sat_inc8 = (val == 8'hFF) ? val : val + 8'd1;
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic       off_evt_s;
    logic       leave_on_s;
    logic       save_ok_s;
    logic       restore_ok_s;
    logic [3:0] err_set_s;
    logic       retain_r;
    logic       restore_done_r;
    logic [3:0] err_r;
    logic [7:0] pso_r;

    // Next-state and ramp counter logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        off_evt_s   = 1'b0;
        case (state_r)
            ST_ON: begin
                if (!pwr1_on26 || !pwr2_on26) begin
                    state_nxt_s = ST_DN_RAMP;
                    cnt_nxt_s   = DN_LOAD;
                end else begin
                    state_nxt_s = ST_ON;
                end
            end
            ST_DN_RAMP: begin
                if (pwr1_on26 && pwr2_on26) begin
                    state_nxt_s = ST_UP1;
                    cnt_nxt_s   = UP1_LOAD;
                end else if (cnt_r == 8'd0) begin
                    state_nxt_s = ST_OFF;
                    off_evt_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end
            end
            ST_OFF: begin
                if (pwr1_on26) begin
                    state_nxt_s = ST_UP1;
                    cnt_nxt_s   = UP1_LOAD;
                end else begin
                    state_nxt_s = ST_OFF;
                end
            end
            ST_UP1: begin
                if (!pwr1_on26) begin
                    state_nxt_s = ST_DN_RAMP;
                    cnt_nxt_s   = DN_LOAD;
                end else if (cnt_r != 8'd0) begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end else if (pwr2_on26) begin
                    state_nxt_s = ST_UP2;
                    cnt_nxt_s   = UP2_LOAD;
                end else begin
                    state_nxt_s = ST_UP1;
                end
            end
            ST_UP2: begin
                if (!pwr1_on26) begin
                    state_nxt_s = ST_DN_RAMP;
                    cnt_nxt_s   = DN_LOAD;
                end else if (cnt_r == 8'd0) begin
                    state_nxt_s = ST_ON;
                end else begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end
            end
            default: begin
                state_nxt_s = ST_ON;
                cnt_nxt_s   = 8'd0;
            end
        endcase
    end

    assign pwr_good26 = (state_r == ST_ON);
    assign pwr1_ack26 = (state_r == ST_ON) || (state_r == ST_UP2);

    // Retention handshake qualification and error-set events
    always_comb begin
        leave_on_s   = (state_r == ST_ON) && (!pwr1_on26 || !pwr2_on26);
        save_ok_s    = save_edge26 && pwr_good26 && isolate_module26 && !restore_edge26;
        restore_ok_s = restore_edge26 && pwr_good26 && retain_r && !save_edge26;
        err_set_s[0] = leave_on_s && !isolate_module26;
        err_set_s[1] = leave_on_s && !gate_clk_module26;
        err_set_s[2] = restore_edge26 && (!pwr_good26 || !retain_r || save_edge26);
        err_set_s[3] = pwr2_on26 && !pwr1_on26;
    end

    // State, counter, retention, error and power-off count registers
    always_ff @(posedge pclk26 or negedge nprst26) begin
        if (!nprst26) begin
            state_r        <= ST_ON;
            cnt_r          <= 8'd0;
            retain_r       <= 1'b0;
            restore_done_r <= 1'b0;
            err_r          <= 4'd0;
            pso_r          <= 8'd0;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            restore_done_r <= restore_ok_s;
            // A set event in the same cycle wins over the clear
            err_r          <= (clr_err26 ? 4'd0 : err_r) | err_set_s;
            if (save_ok_s) begin
                retain_r <= 1'b1;
            end else if (restore_ok_s) begin
                retain_r <= 1'b0;
            end else begin
                retain_r <= retain_r;
            end
            if (off_evt_s) begin
                pso_r <= sat_inc8(pso_r);
            end else begin
                pso_r <= pso_r;
            end
        end
    end

    assign retain_valid26 = retain_r;
    assign restore_done26 = restore_done_r;
    assign err26          = err_r;
    assign pso_count26    = pso_r;

endmodule
